bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares one single-port external memory bus between instruction fetch (pc_reg/if_id side) and data access (mem stage).
- Sequences each access as a multi-cycle bus transaction, returns read data, and drives stall requests into ctrl so the pipeline freezes until the access completes.
- Data access has priority over fetch. A watchdog terminates hung transactions.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for bus_ack before aborting the access; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_ce_i  in  1  fetch request, level-held by requester
- if_addr_i  in  32  fetch address
- if_inst_o  out  32  fetched instruction
- mem_ce_i  in  1  data request, level-held
- mem_we_i  in  1  1=store, 0=load
- mem_addr_i  in  32  data address
- mem_sel_i  in  4  byte enables
- mem_wdata_i  in  32  store data
- mem_rdata_o  out  32  load data
- stall  in  6  pipeline stall vector from ctrl; stall[1]=IF held, stall[4]=MEM held
- stallreq_from_if  out  1  fetch access pending
- stallreq_from_mem  out  1  data access pending
- bus_req_o  out  1  bus cycle active
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  bus address
- bus_sel_o  out  4  bus byte enables
- bus_wdata_o  out  32  bus write data
- bus_ack_i  in  1  slave completion, one-cycle pulse
- bus_rdata_i  in  32  read data, valid with bus_ack_i
- bus_err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including bus_err_o and the timeout counter.
- States:
  - IDLE
  - MEM_BUS
  - IF_BUS
  - MEM_DONE
  - IF_DONE
- IDLE:
  - mem_ce_i=1 → MEM_BUS; latch we/addr/sel/wdata.
  - Else if_ce_i=1 → IF_BUS; latch addr, fetch sel=4'hF, we=0.
  - Both requesting in the same cycle: mem wins; fetch is served afterwards.
- MEM_BUS / IF_BUS:
  - bus_req_o=1; bus_* driven from the latched registers, stable for the whole cycle.
  - On bus_ack_i: capture bus_rdata_i into the matching result register (stores capture 0); go to the matching DONE state.
- Timeout:
  - Counter clears on entry to a BUS state and increments each cycle without ack.
  - When count = TIMEOUT-1 with no ack: result = 32'h0, bus_err_o=1 (cleared only by reset), go to the DONE state.
  - An ack arriving in that same cycle wins over timeout.
- DONE states:
  - Result register drives if_inst_o / mem_rdata_o and holds its value until the next capture.
  - Stay while the consuming stage is held (IF_DONE: stall[1]=1; MEM_DONE: stall[4]=1); otherwise return to IDLE.
  - No back-to-back bus cycles: at least one IDLE cycle between transactions.
- Stall requests (combinational):
  - stallreq_from_mem = mem_ce_i & ~(state==MEM_DONE)
  - stallreq_from_if = if_ce_i & ~(state==IF_DONE)
  - Requester address changes while in a BUS state are ignored; the latched values are used.
- Latency (zero-wait slave, ack in the first BUS cycle): request seen in IDLE → BUS cycle → DONE cycle, i.e. stall asserted exactly 2 cycles.
- Requester drops ce while in a BUS state: the transaction still completes or times out; result is discarded; DONE exits next cycle.
- Reset mid-transaction: bus_req_o drops immediately (async); no retry.

Test Plan:
- Fetch only, if_addr_i=32'h100, ack in the first BUS cycle, rdata=32'h3401_0020:
  - bus_addr_o=32'h100, bus_sel_o=4'hF, bus_we_o=0.
  - stallreq_from_if high 2 cycles.
  - if_inst_o=32'h3401_0020 in IF_DONE.
- Simultaneous requests, if_ce_i=1 and mem_ce_i=1 (load 32'h200):
  - Mem cycle issued first.
  - Fetch issues only after MEM_DONE→IDLE.
  - stallreq_from_if stays high throughout until IF_DONE.
- Store, addr 32'h40, sel 4'b0011, wdata 32'hDEAD_BEEF, ack after 3 wait cycles:
  - bus_* stable for 4 cycles.
  - mem_rdata_o=0.
  - stallreq_from_mem high 5 cycles.
- Hold in DONE, stall[1]=1 for 3 cycles in IF_DONE:
  - State and if_inst_o are held.
  - No new bus_req_o until stall[1]=0.
- Timeout, TIMEOUT=4, never ack:
  - bus_req_o high exactly 4 cycles.
  - bus_err_o=1, mem_rdata_o=0.
  - Stall releases.
- Async reset asserted mid-MEM_BUS: bus_req_o, stall requests and bus_err_o go to 0 without a clock edge.

Source files
------------

// File: rtl/bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and data access.
// Data access wins ties; a watchdog aborts transactions that never see bus_ack_i.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_inst_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  input  logic [5:0]  stall,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {IDLE, MEM_BUS, IF_BUS, MEM_DONE, IF_DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [3:0]  lat_sel;
  logic [31:0] lat_wdata;
  logic [31:0] if_res, mem_res;
  logic        err;
  logic        in_bus, expire;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  assign in_bus = (state == MEM_BUS) || (state == IF_BUS);
  // An ack in the final watchdog cycle takes precedence over the abort.
  assign expire = in_bus && !bus_ack_i && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_ce_i)     state_next = MEM_BUS;
        else if (if_ce_i) state_next = IF_BUS;
      end
      MEM_BUS:  if (bus_ack_i || expire) state_next = MEM_DONE;
      IF_BUS:   if (bus_ack_i || expire) state_next = IF_DONE;
      MEM_DONE: if (!stall[4]) state_next = IDLE;
      IF_DONE:  if (!stall[1]) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Every BUS state is entered from IDLE, so clearing the counter there covers entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_sel   <= '0;
      lat_wdata <= '0;
      if_res    <= '0;
      mem_res   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_ce_i) begin
            lat_we    <= mem_we_i;
            lat_addr  <= mem_addr_i;
            lat_sel   <= mem_sel_i;
            lat_wdata <= mem_wdata_i;
          end else if (if_ce_i) begin
            lat_we    <= 1'b0;
            lat_addr  <= if_addr_i;
            lat_sel   <= '1;
            lat_wdata <= '0;
          end
        end
        MEM_BUS: begin
          if (bus_ack_i) begin
            mem_res <= lat_we ? '0 : bus_rdata_i;
          end else if (expire) begin
            mem_res <= '0;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IF_BUS: begin
          if (bus_ack_i) begin
            if_res <= bus_rdata_i;
          end else if (expire) begin
            if_res <= '0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req_o   = in_bus;
  assign bus_we_o    = in_bus & lat_we;
  assign bus_addr_o  = in_bus ? lat_addr  : '0;
  assign bus_sel_o   = in_bus ? lat_sel   : '0;
  assign bus_wdata_o = in_bus ? lat_wdata : '0;
  assign bus_err_o   = err;

  assign if_inst_o   = if_res;
  assign mem_rdata_o = mem_res;

  // Gated by rst so the requests drop immediately under asynchronous reset.
  assign stallreq_from_mem = rst & mem_ce_i & (state != MEM_DONE);
  assign stallreq_from_if  = rst & if_ce_i  & (state != IF_DONE);

endmodule
